conv1_seq_ctrl: RTL and testbench
=================================

// Module: conv1_seq_ctrl
// PURPOSE
//  Sequencer for the conv1 compute array (NUM_FILT filters x NUM_PXL_OUT_PER_FILT outputs per stride).
//  Loads filter weights once per frame, then walks all output positions row by row, one column group per step.
//  Per step: request a pixel window, wait the fixed compute latency, register the array result and offer it downstream.
//  Sits between the pixel/weight buffers and the pooling/FCL stage.
// PARAMETERS
//  NUM_FILT              6   filters computed in parallel
//  NUM_PXL_OUT_PER_FILT  4   outputs per filter per step (= stride length)
//  ACTV_OUTPUT_WIDTH     22  width of one activation output
//  NUM_OUT_ROWS          28  output rows per frame
//  NUM_COL_GRPS          7   column groups per row (28 cols / 4)
//  COMPUTE_LATENCY       3   cycles from window valid to array output valid (>=1)
//  ROW_W = $clog2(NUM_OUT_ROWS), COL_W = $clog2(NUM_COL_GRPS), DW = NUM_FILT*NUM_PXL_OUT_PER_FILT*ACTV_OUTPUT_WIDTH
// PORTS
//  conv1_ctrl_clk    in   1      clock
//  conv1_ctrl_rst_b  in   1      asynchronous active-low reset
//  start_i           in   1      frame start pulse; ignored unless IDLE
//  abort_i           in   1      abandon frame, return to IDLE next cycle
//  wght_req_o        out  1      request weight load into array
//  wght_vld_i        in   1      weights loaded (ack of wght_req_o)
//  win_req_o         out  1      request pixel window at win_row_o/win_col_o
//  win_row_o         out  ROW_W  output row of requested window
//  win_col_o         out  COL_W  column group of requested window
//  win_vld_i         in   1      window presented to array (ack of win_req_o)
//  conv1_data_i      in   DW     array output (valid COMPUTE_LATENCY cycles after win_vld_i)
//  out_vld_o         out  1      result valid downstream
//  out_rdy_i         in   1      downstream ready
//  out_data_o        out  DW     registered result
//  out_row_o         out  ROW_W  row tag of out_data_o
//  out_col_o         out  COL_W  column-group tag of out_data_o
//  busy_o            out  1      high whenever state != IDLE
//  done_o            out  1      one-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; row/col counters 0; latency counter 0.
//  FSM: IDLE -start_i-> WLOAD -wght_vld_i-> FETCH -win_vld_i-> COMPUTE -lat done-> WRITE -out_rdy_i-> FETCH or DONE -> IDLE.
//  WLOAD: wght_req_o=1 held until the cycle wght_vld_i=1 (inclusive); weights are not reloaded within a frame.
//  FETCH: win_req_o=1 with current row/col, held until win_vld_i=1; req drops the cycle after ack.
//  COMPUTE: counter loaded with COMPUTE_LATENCY-1 on ack; decrements; at 0 conv1_data_i captured into out_data_o
//   together with row/col tags, state->WRITE, out_vld_o=1 next cycle.
//  WRITE: out_vld_o, out_data_o, tags stable until out_vld_o&&out_rdy_i; no new window requested meanwhile.
//  Advance on accept: col+1; col==NUM_COL_GRPS-1 wraps to 0 and row+1; row==NUM_OUT_ROWS-1 && col wrap -> DONE.
//  DONE: done_o=1 for exactly one cycle, counters cleared, -> IDLE; total results per frame = NUM_OUT_ROWS*NUM_COL_GRPS.
//  abort_i (any non-IDLE state, priority over all other events): -> IDLE next cycle, all outputs 0, no done_o.
//  start_i while busy: ignored. start_i and abort_i together in IDLE: abort wins, stay IDLE.
//  Acks arriving in a state that does not expect them (e.g. win_vld_i in WRITE) are ignored.
//  Async reset mid-frame: immediate return to reset values; no partial result delivered.
// TESTING
//  1 Reset: rst_b low mid-COMPUTE -> all outputs 0, busy_o=0 same cycle; release, start_i -> wght_req_o next cycle.
//  2 Full frame, rdy=1, acks 1 cycle after req -> 196 out_vld handshakes, tags (0,0)..(27,6) in order, one done_o.
//  3 Latency: win_vld_i at cycle T -> out_vld_o first high T+COMPUTE_LATENCY+1; data equals conv1_data_i at T+3.
//  4 Backpressure: out_rdy_i low 10 cycles at (5,6) -> data/tags stable, win_req_o=0; on accept next req is (6,0).
//  5 abort_i during FETCH of (3,2) -> IDLE next cycle, no done_o; new start_i restarts at WLOAD and (0,0).
//  6 start_i pulsed during WRITE and wght_vld_i pulsed during FETCH -> no state change, sequence unaffected.

Source files
------------

// File: rtl/conv1_seq_ctrl_if.sv
// Handshake and data bundle between the conv1 sequencer, the pixel/weight buffers
// and the downstream pooling/FCL stage.
interface conv1_seq_ctrl_if #(
  parameter int ROW_W = 5,
  parameter int COL_W = 3,
  parameter int DW    = 528
);
  logic             start_i;
  logic             abort_i;
  logic             wght_req_o;
  logic             wght_vld_i;
  logic             win_req_o;
  logic [ROW_W-1:0] win_row_o;
  logic [COL_W-1:0] win_col_o;
  logic             win_vld_i;
  logic [DW-1:0]    conv1_data_i;
  logic             out_vld_o;
  logic             out_rdy_i;
  logic [DW-1:0]    out_data_o;
  logic [ROW_W-1:0] out_row_o;
  logic [COL_W-1:0] out_col_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    input  start_i, abort_i, wght_vld_i, win_vld_i, conv1_data_i, out_rdy_i,
    output wght_req_o, win_req_o, win_row_o, win_col_o,
           out_vld_o, out_data_o, out_row_o, out_col_o, busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, wght_vld_i, win_vld_i, conv1_data_i, out_rdy_i,
    input  wght_req_o, win_req_o, win_row_o, win_col_o,
           out_vld_o, out_data_o, out_row_o, out_col_o, busy_o, done_o
  );
endinterface

// File: rtl/conv1_seq_ctrl.sv
// Frame sequencer for the conv1 array: one weight load per frame, then one window
// request / fixed-latency compute / downstream handoff per output column group.
module conv1_seq_ctrl #(
  parameter int NUM_FILT             = 6,
  parameter int NUM_PXL_OUT_PER_FILT = 4,
  parameter int ACTV_OUTPUT_WIDTH    = 22,
  parameter int NUM_OUT_ROWS         = 28,
  parameter int NUM_COL_GRPS         = 7,
  parameter int COMPUTE_LATENCY      = 3
) (
  input  logic             conv1_ctrl_clk,
  input  logic             conv1_ctrl_rst_b,
  conv1_seq_ctrl_if.master bus
);

  localparam int ROW_W = (NUM_OUT_ROWS > 1) ? $clog2(NUM_OUT_ROWS) : 1;
  localparam int COL_W = (NUM_COL_GRPS > 1) ? $clog2(NUM_COL_GRPS) : 1;
  localparam int DW    = NUM_FILT * NUM_PXL_OUT_PER_FILT * ACTV_OUTPUT_WIDTH;
  localparam int LAT_W = $clog2(COMPUTE_LATENCY + 1);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_OUT_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL_GRPS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(COMPUTE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_FETCH,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             wght_req;
  logic             win_req;
  logic             out_vld;
  logic             busy;
  logic             done;
  logic [DW-1:0]    out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  logic last_col;
  logic last_pos;
  logic accept;

  assign last_col = (col_cnt == LAST_COL);
  assign last_pos = last_col && (row_cnt == LAST_ROW);
  assign accept   = out_vld && bus.out_rdy_i;

  // Abort outranks every other event in a live frame and wipes all visible state.
  always_ff @(posedge conv1_ctrl_clk or negedge conv1_ctrl_rst_b) begin
    if (!conv1_ctrl_rst_b) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      col_cnt  <= '0;
      lat_cnt  <= '0;
      wght_req <= 1'b0;
      win_req  <= 1'b0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else if ((state != S_IDLE) && bus.abort_i) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      col_cnt  <= '0;
      lat_cnt  <= '0;
      wght_req <= 1'b0;
      win_req  <= 1'b0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            state    <= S_WLOAD;
            wght_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_WLOAD: begin
          if (bus.wght_vld_i) begin
            wght_req <= 1'b0;
            win_req  <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (bus.win_vld_i) begin
            win_req <= 1'b0;
            lat_cnt <= LAT_LOAD;
            state   <= S_COMPUTE;
          end
        end

        // The array result is only guaranteed on the cycle the countdown hits zero.
        S_COMPUTE: begin
          if (lat_cnt == '0) begin
            out_data <= bus.conv1_data_i;
            out_row  <= row_cnt;
            out_col  <= col_cnt;
            out_vld  <= 1'b1;
            state    <= S_WRITE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        S_WRITE: begin
          if (accept) begin
            out_vld <= 1'b0;
            col_cnt <= last_col ? '0 : col_cnt + COL_W'(1);
            if (last_pos) begin
              row_cnt <= '0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              row_cnt <= last_col ? row_cnt + ROW_W'(1) : row_cnt;
              win_req <= 1'b1;
              state   <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          row_cnt <= '0;
          col_cnt <= '0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wght_req_o = wght_req;
  assign bus.win_req_o  = win_req;
  assign bus.win_row_o  = row_cnt;
  assign bus.win_col_o  = col_cnt;
  assign bus.out_vld_o  = out_vld;
  assign bus.out_data_o = out_data;
  assign bus.out_row_o  = out_row;
  assign bus.out_col_o  = out_col;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;

endmodule

// File: tb/tb_conv1_seq_ctrl.sv
// Randomized bench for conv1_seq_ctrl: a driver models the buffers and downstream
// stage, a forked monitor scores every delivered result against a queue.
module tb_conv1_seq_ctrl;

  localparam int NUM_FILT     = 6;
  localparam int NPX          = 4;
  localparam int AW           = 22;
  localparam int NUM_OUT_ROWS = 28;
  localparam int NUM_COL_GRPS = 7;
  localparam int LAT          = 3;
  localparam int ROW_W        = $clog2(NUM_OUT_ROWS);
  localparam int COL_W        = $clog2(NUM_COL_GRPS);
  localparam int DW           = NUM_FILT * NPX * AW;
  localparam int RESULTS      = NUM_OUT_ROWS * NUM_COL_GRPS;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  conv1_seq_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DW(DW)) bus ();

  conv1_seq_ctrl #(
    .NUM_FILT(NUM_FILT),
    .NUM_PXL_OUT_PER_FILT(NPX),
    .ACTV_OUTPUT_WIDTH(AW),
    .NUM_OUT_ROWS(NUM_OUT_ROWS),
    .NUM_COL_GRPS(NUM_COL_GRPS),
    .COMPUTE_LATENCY(LAT)
  ) dut (
    .conv1_ctrl_clk(clk),
    .conv1_ctrl_rst_b(rst_b),
    .bus(bus)
  );

  typedef struct {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [DW-1:0]    data;
    int               vld_cycle;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) d = (d << 32) | DW'($urandom());
    return d;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_busy"}, DW'(bus.busy_o), '0);
    checkOutput({tag, "_wght_req"}, DW'(bus.wght_req_o), '0);
    checkOutput({tag, "_win_req"}, DW'(bus.win_req_o), '0);
    checkOutput({tag, "_out_vld"}, DW'(bus.out_vld_o), '0);
    checkOutput({tag, "_done"}, DW'(bus.done_o), '0);
    checkOutput({tag, "_win_pos"}, DW'({bus.win_row_o, bus.win_col_o}), '0);
    checkOutput({tag, "_out_data"}, bus.out_data_o, '0);
    checkOutput({tag, "_out_tag"}, DW'({bus.out_row_o, bus.out_col_o}), '0);
  endtask

  // Result scoreboard: pops on every downstream handshake, checks latency and stall stability.
  task automatic monitorLoop();
    logic             prev_stall = 1'b0;
    logic             prev_vld = 1'b0;
    logic [DW-1:0]    hold_data = '0;
    logic [ROW_W-1:0] hold_row = '0;
    logic [COL_W-1:0] hold_col = '0;
    int               done_cycle = -1;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        prev_stall = 1'b0;
        prev_vld   = 1'b0;
        done_cycle = -1;
        continue;
      end
      if (bus.done_o || done_cycle == cycle)
        checkOutput("done_pulse", DW'(bus.done_o), DW'(done_cycle == cycle));
      if (prev_stall) begin
        checkOutput("stall_out_vld", DW'(bus.out_vld_o), DW'(1));
        checkOutput("stall_out_data", bus.out_data_o, hold_data);
        checkOutput("stall_out_tag", DW'({bus.out_row_o, bus.out_col_o}), DW'({hold_row, hold_col}));
      end
      prev_stall = 1'b0;
      if (bus.out_vld_o) begin
        checkOutput("win_req_during_write", DW'(bus.win_req_o), '0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_vld", DW'(bus.out_vld_o), '0);
        end else begin
          if (!prev_vld) checkOutput("out_vld_latency", DW'(cycle), DW'(exp_q[0].vld_cycle));
          if (bus.out_rdy_i) begin
            e = exp_q.pop_front();
            checkOutput("out_data", bus.out_data_o, e.data);
            checkOutput("out_row", DW'(bus.out_row_o), DW'(e.row));
            checkOutput("out_col", DW'(bus.out_col_o), DW'(e.col));
            if (int'(e.row) == NUM_OUT_ROWS - 1 && int'(e.col) == NUM_COL_GRPS - 1)
              done_cycle = cycle + 1;
          end else begin
            prev_stall = 1'b1;
            hold_data  = bus.out_data_o;
            hold_row   = bus.out_row_o;
            hold_col   = bus.out_col_o;
          end
        end
      end
      prev_vld = bus.out_vld_o;
    end
  endtask

  // One frame of buffer/downstream behaviour; abort_* and hold_* of -1 disable those events.
  task automatic applyStimulus(input int ack_pct, input int rdy_pct, input bit noise,
                               input int abort_row, input int abort_col,
                               input int hold_row, input int hold_col);
    int               r = 0;
    int               c = 0;
    bit               pend = 1'b0;
    int               pend_cnt = 0;
    logic [ROW_W-1:0] pend_row = '0;
    logic [COL_W-1:0] pend_col = '0;
    int               stall_left = 10;
    int               pushed = 0;
    bit               finished = 1'b0;
    bit               aborted = 1'b0;
    logic [DW-1:0]    d;

    @(posedge clk); #1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    checkOutput("wght_req_after_start", DW'(bus.wght_req_o), DW'(1));
    checkOutput("busy_after_start", DW'(bus.busy_o), DW'(1));

    for (int budget = 0; budget < 20000 && !finished; budget++) begin
      if (pend) pend_cnt--;
      if (pend && pend_cnt == 0) begin
        d = rand_data();
        bus.conv1_data_i = d;
        exp_q.push_back('{row: pend_row, col: pend_col, data: d, vld_cycle: cycle + 1});
        pushed++;
        pend = 1'b0;
      end else begin
        bus.conv1_data_i = rand_data();
      end

      bus.wght_vld_i = bus.wght_req_o ? pct(ack_pct) : (noise && $urandom_range(15, 0) == 0);
      bus.abort_i    = 1'b0;
      bus.win_vld_i  = 1'b0;
      if (bus.win_req_o) begin
        if (r == abort_row && c == abort_col) begin
          bus.abort_i = 1'b1;
          aborted     = 1'b1;
        end else if (pct(ack_pct)) begin
          checkOutput("win_row", DW'(bus.win_row_o), DW'(r));
          checkOutput("win_col", DW'(bus.win_col_o), DW'(c));
          bus.win_vld_i = 1'b1;
          pend          = 1'b1;
          pend_cnt      = LAT;
          pend_row      = ROW_W'(r);
          pend_col      = COL_W'(c);
          c++;
          if (c == NUM_COL_GRPS) begin
            c = 0;
            r++;
          end
        end
      end else begin
        bus.win_vld_i = noise && $urandom_range(7, 0) == 0;
      end

      if (bus.out_vld_o && int'(bus.out_row_o) == hold_row &&
          int'(bus.out_col_o) == hold_col && stall_left > 0) begin
        bus.out_rdy_i = 1'b0;
        stall_left--;
      end else begin
        bus.out_rdy_i = pct(rdy_pct);
      end
      bus.start_i = noise && bus.busy_o && $urandom_range(15, 0) == 0;
      if (bus.done_o) finished = 1'b1;

      @(posedge clk); #1;
      if (aborted) begin
        bus.abort_i = 1'b0;
        checkAllIdle("after_abort");
        exp_q.delete();
        break;
      end
    end

    bus.start_i    = 1'b0;
    bus.wght_vld_i = 1'b0;
    bus.win_vld_i  = 1'b0;
    bus.out_rdy_i  = 1'b0;
    if (!aborted) begin
      checkOutput("frame_completed", DW'(finished), DW'(1));
      checkOutput("results_per_frame", DW'(pushed), DW'(RESULTS));
      checkOutput("busy_after_done", DW'(bus.busy_o), '0);
      checkOutput("done_single_cycle", DW'(bus.done_o), '0);
    end
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.abort_i      = 1'b0;
    bus.wght_vld_i   = 1'b0;
    bus.win_vld_i    = 1'b0;
    bus.conv1_data_i = '0;
    bus.out_rdy_i    = 1'b0;
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkAllIdle("reset");
    rst_b = 1'b1;

    // start together with abort in IDLE must not start a frame
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    checkOutput("start_abort_idle_busy", DW'(bus.busy_o), '0);
    checkOutput("start_abort_idle_wreq", DW'(bus.wght_req_o), '0);

    // walk into COMPUTE, then pull reset asynchronously
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    checkOutput("manual_wght_req", DW'(bus.wght_req_o), DW'(1));
    bus.wght_vld_i = 1'b1;
    @(posedge clk); #1;
    bus.wght_vld_i = 1'b0;
    checkOutput("manual_win_req", DW'(bus.win_req_o), DW'(1));
    checkOutput("manual_wght_req_drop", DW'(bus.wght_req_o), '0);
    bus.win_vld_i = 1'b1;
    @(posedge clk); #1;
    bus.win_vld_i = 1'b0;
    checkOutput("manual_win_req_drop", DW'(bus.win_req_o), '0);
    checkOutput("manual_busy", DW'(bus.busy_o), DW'(1));
    #2;
    rst_b = 1'b0;
    #1;
    checkAllIdle("async_reset");
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    checkOutput("restart_wght_req", DW'(bus.wght_req_o), DW'(1));
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    checkAllIdle("abort_wload");

    $display("[TB] clean frame");
    applyStimulus(100, 100, 1'b0, -1, -1, -1, -1);
    $display("[TB] random frame with stall at (5,6)");
    applyStimulus(60, 70, 1'b1, -1, -1, 5, 6);
    $display("[TB] frame aborted at (3,2)");
    applyStimulus(70, 80, 1'b1, 3, 2, -1, -1);
    $display("[TB] frame after abort");
    applyStimulus(50, 60, 1'b1, -1, -1, -1, -1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
